// File: rtl/inst_rom_ctrl.sv
// Instruction fetch bridge: one-word buffer in front of an 8-bit external ROM.
// A miss stalls the CPU while four big-endian bytes are read, each held WAIT_CYCLES+1 cycles.
module inst_rom_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce,
    input  logic [31:0] rom_addr,
    output logic [31:0] rom_inst,
    output logic        stall_req,
    output logic [19:0] mem_addr,
    output logic        mem_oe_n,
    input  logic [7:0]  mem_data
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    localparam logic [2:0] WAIT_MAX = 3'(WAIT_CYCLES);

    state_t      state_r;
    logic        valid_r;
    logic [29:0] tag_r;
    logic [31:0] data_r;
    logic [29:0] fetch_addr_r;
    logic [23:0] fill_r;
    logic [1:0]  byte_idx_r;
    logic [2:0]  wait_cnt_r;
    logic [19:0] mem_addr_r;
    logic        mem_oe_n_r;

    logic        hit_s;
    logic [31:0] rom_inst_s;
    logic        stall_req_s;
    logic        unused_s;

    assign hit_s    = rom_ce & valid_r & (tag_r == rom_addr[31:2]);
    assign unused_s = ^rom_addr[1:0];

    // CPU-facing response; reset and a disabled fetch force both outputs low
    always_comb begin
        rom_inst_s  = 32'h0000_0000;
        stall_req_s = 1'b0;
        if (!rst || !rom_ce) begin
            rom_inst_s  = 32'h0000_0000;
            stall_req_s = 1'b0;
        end else if (state_r == ST_READ) begin
            stall_req_s = 1'b1;
        end else if (hit_s) begin
            rom_inst_s = data_r;
        end else begin
            stall_req_s = 1'b1;
        end
    end

    assign rom_inst  = rom_inst_s;
    assign stall_req = stall_req_s;
    assign mem_addr  = mem_addr_r;
    assign mem_oe_n  = mem_oe_n_r;

    // Fetch sequencer; mem_addr/mem_oe_n are loaded one edge ahead so they are registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            valid_r      <= 1'b0;
            tag_r        <= 30'd0;
            data_r       <= 32'h0000_0000;
            fetch_addr_r <= 30'd0;
            fill_r       <= 24'h00_0000;
            byte_idx_r   <= 2'd0;
            wait_cnt_r   <= 3'd0;
            mem_addr_r   <= 20'h0_0000;
            mem_oe_n_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rom_ce && !hit_s) begin
                        fetch_addr_r <= rom_addr[31:2];
                        byte_idx_r   <= 2'd0;
                        wait_cnt_r   <= 3'd0;
                        mem_addr_r   <= {rom_addr[19:2], 2'd0};
                        mem_oe_n_r   <= 1'b0;
                        state_r      <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!rom_ce) begin
                        byte_idx_r <= 2'd0;
                        wait_cnt_r <= 3'd0;
                        mem_oe_n_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else if (wait_cnt_r == WAIT_MAX) begin
                        wait_cnt_r <= 3'd0;
                        if (byte_idx_r == 2'd3) begin
                            // Whole word lands at once; the buffer never holds a partial fill
                            data_r     <= {fill_r, mem_data};
                            tag_r      <= fetch_addr_r;
                            valid_r    <= 1'b1;
                            byte_idx_r <= 2'd0;
                            mem_oe_n_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            case (byte_idx_r)
                                2'd0:    fill_r[23:16] <= mem_data;
                                2'd1:    fill_r[15:8]  <= mem_data;
                                default: fill_r[7:0]   <= mem_data;
                            endcase
                            byte_idx_r <= byte_idx_r + 2'd1;
                            mem_addr_r <= {fetch_addr_r[17:0], byte_idx_r + 2'd1};
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench for inst_rom_ctrl: two instances (WAIT_CYCLES=1 and 0) share CPU-side stimulus,
// checked every cycle against a cycle-count model plus hand-computed literals.
module tb_inst_rom_ctrl;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;

    logic [31:0] inst_w1, inst_w0;
    logic        stall_w1, stall_w0;
    logic [19:0] maddr_w1, maddr_w0;
    logic        oe_w1, oe_w0;
    logic [7:0]  mdata_w1, mdata_w0;

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] mb(input logic [19:0] a);
        logic [7:0] t;
        case (a)
            20'd0:   t = 8'h34;
            20'd1:   t = 8'h01;
            20'd2:   t = 8'h00;
            20'd3:   t = 8'h20;
            default: t = a[7:0] * 8'd7 + 8'd3;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] word_at(input logic [29:0] a);
        return {mb({a[17:0], 2'd0}), mb({a[17:0], 2'd1}), mb({a[17:0], 2'd2}), mb({a[17:0], 2'd3})};
    endfunction

    assign mdata_w1 = mb(maddr_w1);
    assign mdata_w0 = mb(maddr_w0);

    inst_rom_ctrl #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr),
        .rom_inst(inst_w1), .stall_req(stall_w1), .mem_addr(maddr_w1),
        .mem_oe_n(oe_w1), .mem_data(mdata_w1)
    );

    inst_rom_ctrl #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr),
        .rom_inst(inst_w0), .stall_req(stall_w0), .mem_addr(maddr_w0),
        .mem_oe_n(oe_w0), .mem_data(mdata_w0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: a fetch is just "busy for k cycles"; byte shown is k/(W+1)
    logic        m_ready;
    logic        m_valid[2];
    logic [29:0] m_tag[2];
    logic [31:0] m_data[2];
    logic        m_busy[2];
    logic [29:0] m_addr[2];
    int          m_k[2];
    logic [19:0] m_last[2];

    function automatic int wc(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [19:0] disp(input int i);
        logic [1:0] b;
        b = 2'(m_k[i] / (wc(i) + 1));
        return m_busy[i] ? {m_addr[i][17:0], b} : m_last[i];
    endfunction

    always @(posedge clk) begin
        if (!rst) m_ready <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_valid[i] <= 1'b0;
                m_tag[i]   <= 30'd0;
                m_data[i]  <= 32'd0;
                m_busy[i]  <= 1'b0;
                m_k[i]     <= 0;
                m_last[i]  <= 20'd0;
            end else if (m_busy[i]) begin
                m_last[i] <= disp(i);
                if (!rom_ce) begin
                    m_busy[i] <= 1'b0;
                end else if (m_k[i] == 4 * (wc(i) + 1) - 1) begin
                    m_valid[i] <= 1'b1;
                    m_tag[i]   <= m_addr[i];
                    m_data[i]  <= word_at(m_addr[i]);
                    m_busy[i]  <= 1'b0;
                end else begin
                    m_k[i] <= m_k[i] + 1;
                end
            end else if (rom_ce && !(m_valid[i] && m_tag[i] == rom_addr[31:2])) begin
                m_busy[i] <= 1'b1;
                m_addr[i] <= rom_addr[31:2];
                m_k[i]    <= 0;
            end
        end
    end

    logic [31:0] a_inst[2];
    logic        a_stall[2];
    logic [19:0] a_maddr[2];
    logic        a_oe[2];
    assign a_inst[0]  = inst_w1;  assign a_inst[1]  = inst_w0;
    assign a_stall[0] = stall_w1; assign a_stall[1] = stall_w0;
    assign a_maddr[0] = maddr_w1; assign a_maddr[1] = maddr_w0;
    assign a_oe[0]    = oe_w1;    assign a_oe[1]    = oe_w0;

    initial m_ready = 1'b0;

    always @(negedge clk) begin
        if (m_ready) begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] e_inst;
                logic        e_stall;
                e_inst  = 32'd0;
                e_stall = 1'b0;
                if (rst && rom_ce) begin
                    if (m_busy[i]) e_stall = 1'b1;
                    else if (m_valid[i] && m_tag[i] == rom_addr[31:2]) e_inst = m_data[i];
                    else e_stall = 1'b1;
                end
                check($sformatf("u%0d.rom_inst", i), a_inst[i], e_inst);
                check($sformatf("u%0d.stall_req", i), 32'(a_stall[i]), 32'(e_stall));
                check($sformatf("u%0d.mem_oe_n", i), 32'(a_oe[i]), 32'(!m_busy[i]));
                check($sformatf("u%0d.mem_addr", i), 32'(a_maddr[i]), 32'(disp(i)));
            end
        end
    end

    logic [19:0] q1[$];
    logic [19:0] q0[$];

    task automatic drive(input logic ce, input logic [31:0] addr, input logic r);
        @(posedge clk);
        #1;
        rst      = r;
        rom_ce   = ce;
        rom_addr = addr;
    endtask

    task automatic run_count(input int n, output int s1, output int s0);
        s1 = 0;
        s0 = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            s1 += int'(stall_w1);
            s0 += int'(stall_w0);
            if (!oe_w1) q1.push_back(maddr_w1);
            if (!oe_w0) q0.push_back(maddr_w0);
        end
    endtask

    initial begin
        int s1, s0;
        rst      = 1'b0;
        rom_ce   = 1'b0;
        rom_addr = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset rom_inst", inst_w1, 32'h0000_0000);
        check("reset stall_req", 32'(stall_w1), 32'd0);
        check("reset mem_oe_n", 32'(oe_w1), 32'd1);
        check("reset mem_addr", 32'(maddr_w1), 32'd0);

        // First fill from address 0
        drive(1'b1, 32'h0000_0000, 1'b1);
        q1.delete();
        q0.delete();
        run_count(15, s1, s0);
        check("fill0 stall cycles w1", 32'(s1), 32'd9);
        check("fill0 stall cycles w0", 32'(s0), 32'd5);
        check("fill0 read cycles w1", 32'(q1.size()), 32'd8);
        check("fill0 read cycles w0", 32'(q0.size()), 32'd4);
        for (int j = 0; j < q1.size() && j < 8; j++)
            check($sformatf("fill0 w1 mem_addr[%0d]", j), 32'(q1[j]), 32'(j / 2));
        for (int j = 0; j < q0.size() && j < 4; j++)
            check($sformatf("fill0 w0 mem_addr[%0d]", j), 32'(q0[j]), 32'(j));
        check("fill0 rom_inst", inst_w1, 32'h3401_0020);
        check("fill0 hit stall", 32'(stall_w1), 32'd0);
        check("fill0 hit mem_oe_n", 32'(oe_w1), 32'd1);

        // Word at 4, then byte offset 6 within it, then aliasing address above bit 19
        drive(1'b1, 32'h0000_0004, 1'b1);
        run_count(12, s1, s0);
        check("fill4 stall cycles w1", 32'(s1), 32'd9);
        drive(1'b1, 32'h0000_0006, 1'b1);
        @(negedge clk);
        #1;
        check("addr6 hit stall", 32'(stall_w1), 32'd0);
        check("addr6 hit rom_inst", inst_w1, 32'h1F26_2D34);
        drive(1'b1, 32'h0010_0004, 1'b1);
        @(negedge clk);
        #1;
        check("high tag miss stall", 32'(stall_w1), 32'd1);
        @(negedge clk);
        #1;
        check("high tag mem_addr", 32'(maddr_w1), 32'h0_0004);
        check("high tag mem_oe_n", 32'(oe_w1), 32'd0);
        run_count(12, s1, s0);
        check("high tag rom_inst", inst_w1, 32'h1F26_2D34);

        // Abort during byte 2, then full refetch
        drive(1'b1, 32'h0000_0008, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        check("abort byte2 mem_addr", 32'(maddr_w1), 32'h0_000A);
        drive(1'b0, 32'h0000_0008, 1'b1);
        @(negedge clk);
        #1;
        check("abort ce0 stall", 32'(stall_w1), 32'd0);
        @(negedge clk);
        #1;
        check("abort mem_oe_n", 32'(oe_w1), 32'd1);
        drive(1'b1, 32'h0000_0008, 1'b1);
        run_count(15, s1, s0);
        check("refetch stall cycles w1", 32'(s1), 32'd9);
        check("refetch stall cycles w0", 32'(s0), 32'd0);
        check("refetch rom_inst", inst_w1, 32'h3B42_4950);

        // Reset during byte 1
        drive(1'b1, 32'h0000_000C, 1'b1);
        repeat (4) @(negedge clk);
        drive(1'b1, 32'h0000_000C, 1'b0);
        @(negedge clk);
        #1;
        check("rst held stall", 32'(stall_w1), 32'd0);
        check("rst held rom_inst", inst_w1, 32'h0000_0000);
        drive(1'b1, 32'h0000_000C, 1'b1);
        @(negedge clk);
        #1;
        check("post rst mem_addr", 32'(maddr_w1), 32'd0);
        check("post rst mem_oe_n", 32'(oe_w1), 32'd1);
        check("post rst miss stall", 32'(stall_w1), 32'd1);
        run_count(14, s1, s0);
        check("post rst stall cycles w1", 32'(s1), 32'd8);
        check("post rst stall cycles w0", 32'(s0), 32'd4);
        check("post rst rom_inst", inst_w1, 32'h575E_656C);

        // Address change mid-fill is ignored, then missed afresh
        drive(1'b1, 32'h0000_0010, 1'b1);
        repeat (3) @(negedge clk);
        drive(1'b1, 32'h0000_0014, 1'b1);
        repeat (20) @(negedge clk);
        drive(1'b0, 32'h0000_0000, 1'b1);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
